// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: segment vector type, blank pattern and
// the hex glyph table used by every display block.
package ssd_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b0000000;

   // Hex glyphs in {a,b,c,d,e,f,g} order, active-high segments.
   function automatic seg_t hex_to_seg(input logic [3:0] hex);
      seg_t s;
      case (hex)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Scan timer for the multiplexed SSD bus: holds each digit for SCAN_DIV
// clocks, then advances the scan index and rotates the one-hot select.
module ssd_scan_timer
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int SCAN_DIV   = 62_500,
   localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   output logic [IDX_W-1:0]      scan_idx,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic                  scan_adv
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_p0;

   assign scan_adv = (cnt_p0 == CNT_LAST);

   // Dwell counter: 0..SCAN_DIV-1, restarts on the advance strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_p0 <= '0;
      else if (scan_adv)
         cnt_p0 <= '0;
      else
         cnt_p0 <= cnt_p0 + CNT_W'(1);
   end

   generate
      if (NUM_DIGITS == 1) begin : g_single
         // A single digit is always selected; nothing rotates.
         assign scan_idx = '0;
         assign dig_sel  = 1'b1;
      end else begin : g_ring
         localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
         logic [IDX_W-1:0]      idx_p0;
         logic [NUM_DIGITS-1:0] sel_p0;

         // Index and one-hot select advance together so they never disagree.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               idx_p0 <= '0;
               sel_p0 <= NUM_DIGITS'(1);
            end else if (scan_adv) begin
               idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
               sel_p0 <= {sel_p0[NUM_DIGITS-2:0], sel_p0[NUM_DIGITS-1]};
            end
         end

         assign scan_idx = idx_p0;
         assign dig_sel  = sel_p0;
      end
   endgenerate

endmodule

// File: rtl/ssd_entry_scanner.sv
// Keypad entry buffer with multiplexed seven-segment scan-out.
// Keeps the last NUM_DIGITS keys (newest in slot 0) and drives one shared
// segment bus with a rotating one-hot digit select.
// Optional build macro SSD_ENTRY_BKSP_EN: key BKSP_CODE deletes the newest
// digit instead of being stored.
module ssd_entry_scanner
   import ssd_pkg::*;
#(
   parameter int         NUM_DIGITS = 2,
   parameter int         SCAN_DIV   = 62_500,
   parameter logic [3:0] BKSP_CODE  = 4'hE,
   localparam int        CNT_W      = $clog2(NUM_DIGITS + 1)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   input  logic                  clear,
   input  logic                  stop_full,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  overflow
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic                  key_prev_p0;
   logic                  key_evt;
   logic                  is_bksp;
   logic [3:0]            dig_p0  [NUM_DIGITS];
   logic [3:0]            dig_nxt [NUM_DIGITS];
   logic [CNT_W-1:0]      cnt_nxt;
   logic                  ovf_nxt;
   logic [NUM_DIGITS-1:0] slot_vld;
   logic [IDX_W-1:0]      scan_idx;
   logic [IDX_W-1:0]      idx_nxt;
   logic                  scan_adv;

   // Count increment that holds at the buffer depth.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_FULL) ? c : c + CNT_W'(1);
   endfunction

   ssd_scan_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV)
   ) u_scan_timer (
      .clk      (clk),
      .rst      (rst),
      .scan_idx (scan_idx),
      .dig_sel  (dig_sel),
      .scan_adv (scan_adv)
   );

   // Rising edge of key_valid; prev resets high so a key held through reset is ignored.
   assign key_evt = key_valid & ~key_prev_p0;

`ifdef SSD_ENTRY_BKSP_EN
   assign is_bksp = (key_code == BKSP_CODE);
`else
   // BKSP_CODE is an ordinary digit in this build.
   assign is_bksp = 1'b0 & (key_code == BKSP_CODE);
`endif

   assign full = (count == CNT_FULL);

   // Slots below count hold valid digits; the rest display blank.
   always_comb begin
      slot_vld = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         slot_vld[i] = (CNT_W'(i) < count);
   end

   // Next buffer state: clear wins, then backspace, stop-mode reject, shift-in.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++)
         dig_nxt[i] = dig_p0[i];
      cnt_nxt = count;
      ovf_nxt = 1'b0;
      if (clear) begin
         cnt_nxt = '0;
      end else if (key_evt) begin
         if (is_bksp) begin
            if (count != '0) begin
               for (int i = 0; i < NUM_DIGITS - 1; i++)
                  dig_nxt[i] = dig_p0[i+1];
               cnt_nxt = count - CNT_W'(1);
            end
         end else if (stop_full && full) begin
            ovf_nxt = 1'b1;
         end else begin
            for (int i = NUM_DIGITS - 1; i > 0; i--)
               dig_nxt[i] = dig_p0[i-1];
            dig_nxt[0] = key_code;
            cnt_nxt    = sat_inc(count);
         end
      end
   end

   // Digit storage; validity is carried by count, so the data needs no reset.
   always_ff @(posedge clk) begin
      dig_p0 <= dig_nxt;
   end

   // Control state: edge detector, occupancy and overflow pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_prev_p0 <= 1'b1;
         count       <= '0;
         overflow    <= 1'b0;
      end else begin
         key_prev_p0 <= key_valid;
         count       <= cnt_nxt;
         overflow    <= ovf_nxt;
      end
   end

   assign idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);

   // Segment bus loads the glyph for the digit being selected on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         seg <= SEG_BLANK;
      else if (scan_adv)
         seg <= slot_vld[idx_nxt] ? hex_to_seg(dig_p0[idx_nxt]) : SEG_BLANK;
   end

endmodule
